// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus arbiter slice: FSM state encoding,
// index-width helper and the slave-wait counter width.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } bus_state_e;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned WAIT_CNT_W = 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit scanning upward from
// last+1, wrapping modulo N.
module rr_picker
  import bus_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    int unsigned idx;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(last) + (N - off)) % N;
      if (req[IDX_W'(idx)]) begin
        gnt_idx = IDX_W'(idx);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin N-master to single-slave bus arbiter with a slave-wait
// timeout; one transaction in flight, request fields latched at grant.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS-1:0]        m_wr,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic                          s_valid,
  output logic                          s_wr,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic [idx_w(NUM_MASTERS)-1:0] grant_id,
  output logic                          busy
);

  localparam int unsigned IDX_W = idx_w(NUM_MASTERS);
  localparam logic [WAIT_CNT_W-1:0] TMO = WAIT_CNT_W'(TIMEOUT);

  bus_state_e            state_q, state_d;
  logic                  s_wr_q, s_wr_d;
  logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
  logic [DATA_W-1:0]     s_wdata_q, s_wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;

  rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (m_valid),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    s_wr_d    = s_wr_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wait_d    = wait_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = ISSUE;
          grant_d   = pick_idx;
          last_d    = pick_idx;
          s_wr_d    = m_wr[pick_idx];
          s_addr_d  = m_addr[pick_idx*ADDR_W +: ADDR_W];
          s_wdata_d = m_wdata[pick_idx*DATA_W +: DATA_W];
          wait_d    = '0;
        end
      end
      ISSUE: begin
        // A response in the same cycle the counter expires still completes.
        if (s_ready) begin
          rdata_d = s_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wait_q == TMO) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d = wait_q + WAIT_CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_wr_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_wr_q    <= s_wr_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    m_ready = '0;
    if (state_q == RESP) m_ready[grant_q] = 1'b1;
  end

  assign s_valid  = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign s_wr     = s_wr_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m_rdata  = rdata_q;
  assign m_err    = err_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: default 4-master instance with a
// random-latency slave, plus a 2-master wide instance with an always-ready slave.
module tb_bus_arbiter;

  localparam int unsigned TMO = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Instance A: defaults
  logic [3:0]  m_valid_a = '0, m_wr_a = '0, m_ready_a;
  logic [15:0] m_addr_a = '0, m_wdata_a = '0;
  logic [3:0]  m_rdata_a, s_addr_a, s_wdata_a, s_rdata_a;
  logic        m_err_a, s_valid_a, s_wr_a, busy_a;
  logic        s_ready_a = 1'b0;
  logic [1:0]  grant_id_a;

  bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(4), .DATA_W(4), .TIMEOUT(TMO)) dut_a (
    .clock(clock), .reset(reset), .m_valid(m_valid_a), .m_wr(m_wr_a),
    .m_addr(m_addr_a), .m_wdata(m_wdata_a), .m_ready(m_ready_a),
    .m_rdata(m_rdata_a), .m_err(m_err_a), .s_valid(s_valid_a), .s_wr(s_wr_a),
    .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_rdata(s_rdata_a),
    .s_ready(s_ready_a), .grant_id(grant_id_a), .busy(busy_a)
  );

  // Instance B: two wide masters, slave always ready
  logic [1:0]  m_valid_b = '0, m_wr_b = '0, m_ready_b;
  logic [15:0] m_addr_b = '0;
  logic [31:0] m_wdata_b = '0;
  logic [15:0] m_rdata_b, s_wdata_b, s_rdata_b;
  logic [7:0]  s_addr_b;
  logic        m_err_b, s_valid_b, s_wr_b, busy_b;
  logic [0:0]  grant_id_b;

  assign s_rdata_b = {s_addr_b, ~s_addr_b};

  bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(8), .DATA_W(16)) dut_b (
    .clock(clock), .reset(reset), .m_valid(m_valid_b), .m_wr(m_wr_b),
    .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_ready(m_ready_b),
    .m_rdata(m_rdata_b), .m_err(m_err_b), .s_valid(s_valid_b), .s_wr(s_wr_b),
    .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_rdata(s_rdata_b),
    .s_ready(1'b1), .grant_id(grant_id_b), .busy(busy_b)
  );

  typedef struct {
    int unsigned master;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned issue_cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference state: who was served last, per instance
  int unsigned last_a = 3;
  int unsigned last_b = 1;

  int unsigned slv_delay = 0;
  logic [3:0]  slv_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int unsigned next_owner(input logic [31:0] mask, input int unsigned n,
                                             input int unsigned last);
    int unsigned i = last;
    do i = (i + 1) % n; while (!mask[i]);
    return i;
  endfunction

  // Slave for instance A: ready after slv_delay ISSUE cycles; noise otherwise
  initial forever begin
    int unsigned cnt;
    @(negedge clock);
    if (s_valid_a) begin
      s_ready_a = (cnt == slv_delay);
      s_rdata_a = s_ready_a ? slv_data : 4'($urandom);
      cnt++;
    end else begin
      cnt = 0;
      s_ready_a = 1'($urandom_range(0, 1));
      s_rdata_a = 4'($urandom);
    end
  end

  // Monitor A
  initial forever begin
    logic sv_prev;
    int unsigned issue_cnt;
    exp_t e;
    @(negedge clock);
    if (reset) begin
      sv_prev = 1'b0;
      issue_cnt = 0;
    end else begin
      if (s_valid_a) begin
        if (!sv_prev) issue_cnt = 0;
        issue_cnt++;
        if (qa.size() == 0) flag("a_spurious_s_valid");
        else begin
          chk("a_s_addr", 32'(s_addr_a), qa[0].addr);
          chk("a_s_wr", 32'(s_wr_a), 32'(qa[0].wr));
          chk("a_s_wdata", 32'(s_wdata_a), qa[0].wdata);
          chk("a_grant_id", 32'(grant_id_a), qa[0].master);
          chk("a_busy", 32'(busy_a), 32'd1);
        end
      end
      if (m_ready_a != '0) begin
        if (qa.size() == 0) flag("a_spurious_m_ready");
        else begin
          e = qa.pop_front();
          chk("a_m_ready", 32'(m_ready_a), 32'd1 << e.master);
          chk("a_m_rdata", 32'(m_rdata_a), e.rdata);
          chk("a_m_err", 32'(m_err_a), 32'(e.err));
          chk("a_latency", issue_cnt, e.issue_cyc);
          chk("a_resp_s_valid", 32'(s_valid_a), 32'd0);
        end
      end
      sv_prev = s_valid_a;
    end
  end

  // Monitor B
  initial forever begin
    logic sv_prev;
    int cyc;
    int last_rise;
    exp_t e;
    @(negedge clock);
    if (reset) begin
      sv_prev = 1'b0;
      last_rise = -1;
    end else begin
      cyc++;
      if (s_valid_b && !sv_prev) begin
        if (last_rise >= 0) chk("b_spacing", 32'(cyc - last_rise), 32'd3);
        last_rise = cyc;
      end
      if (s_valid_b) begin
        if (qb.size() == 0) flag("b_spurious_s_valid");
        else begin
          chk("b_s_addr", 32'(s_addr_b), qb[0].addr);
          chk("b_s_wdata", 32'(s_wdata_b), qb[0].wdata);
          chk("b_s_wr", 32'(s_wr_b), 32'(qb[0].wr));
          chk("b_grant_id", 32'(grant_id_b), qb[0].master);
        end
      end
      if (m_ready_b != '0) begin
        if (qb.size() == 0) flag("b_spurious_m_ready");
        else begin
          e = qb.pop_front();
          chk("b_m_ready", 32'(m_ready_b), 32'd1 << e.master);
          chk("b_m_rdata", 32'(m_rdata_b), e.rdata);
          chk("b_m_err", 32'(m_err_b), 32'd0);
        end
      end
      sv_prev = s_valid_b;
    end
  end

  task automatic wait_idle_a();
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      #1;
      if (qa.size() == 0 && !busy_a) return;
    end
    flag("a_idle_timeout");
    qa.delete();
  endtask

  task automatic issue_a(input logic [3:0] mask, input int unsigned d, input bit scramble,
                         input logic [15:0] addrs, input logic [15:0] wdatas,
                         input logic [3:0] wrs, input logic [3:0] rdata);
    exp_t e;
    int unsigned w;
    wait_idle_a();
    m_addr_a  = addrs;
    m_wdata_a = wdatas;
    m_wr_a    = wrs;
    slv_delay = d;
    slv_data  = rdata;
    w = next_owner(32'(mask), 4, last_a);
    last_a = w;
    e.master    = w;
    e.wr        = wrs[w];
    e.addr      = 32'(addrs[w*4 +: 4]);
    e.wdata     = 32'(wdatas[w*4 +: 4]);
    e.err       = (d > TMO);
    e.rdata     = e.err ? 32'd0 : 32'(rdata);
    e.issue_cyc = e.err ? TMO + 1 : d + 1;
    qa.push_back(e);
    m_valid_a = mask;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (busy_a) break;
    end
    m_valid_a = '0;
    if (scramble) begin
      m_addr_a  = 16'($urandom);
      m_wdata_a = 16'($urandom);
      m_wr_a    = 4'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned seen;
    logic [3:0] mask;
    int unsigned d, r;
    exp_t e;

    #12;
    chk("rst_s_valid", 32'(s_valid_a), 0);
    chk("rst_s_addr", 32'(s_addr_a), 0);
    chk("rst_m_ready", 32'(m_ready_a), 0);
    chk("rst_m_rdata", 32'(m_rdata_a), 0);
    chk("rst_m_err", 32'(m_err_a), 0);
    chk("rst_grant_id", 32'(grant_id_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    @(negedge clock);
    reset = 1'b0;

    // All four masters requesting continuously with an immediate slave
    wait_idle_a();
    m_addr_a = 16'($urandom); m_wdata_a = 16'($urandom); m_wr_a = 4'($urandom);
    slv_delay = 0; slv_data = 4'hA;
    for (int k = 0; k < 5; k++) begin
      last_a = next_owner(32'hF, 4, last_a);
      e.master = last_a; e.wr = m_wr_a[last_a];
      e.addr = 32'(m_addr_a[last_a*4 +: 4]); e.wdata = 32'(m_wdata_a[last_a*4 +: 4]);
      e.err = 1'b0; e.rdata = 32'hA; e.issue_cyc = 1;
      qa.push_back(e);
    end
    m_valid_a = 4'hF;
    seen = 0;
    for (int n = 0; n < 100 && seen < 5; n++) begin
      @(negedge clock);
      if (m_ready_a != '0) seen++;
    end
    m_valid_a = '0;
    if (seen < 5) flag("a_rotation_timeout");

    // Basic read from master 0
    issue_a(4'b0001, 2, 0, 16'h000C, 16'h0003, 4'b0000, 4'hA);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      do mask = 4'($urandom); while (mask == '0);
      r = $urandom_range(0, 9);
      d = (r < 7) ? $urandom_range(0, 4) : ((r < 9) ? 14 : $urandom_range(16, 20));
      issue_a(mask, d, 1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
    end

    // Master 2 alone, dropping and changing its fields right after grant
    issue_a(4'b0100, 1, 1, 16'h0B00, 16'h0500, 4'b0100, 4'h6);

    // Slave never answers, then a normal transaction
    issue_a(4'b0001, 255, 0, 16'h0009, 16'h0001, 4'b0001, 4'h3);
    issue_a(4'b1000, 0, 0, 16'h7000, 16'h2000, 4'b0000, 4'h5);

    // Reset in the middle of ISSUE
    issue_a(4'b0010, 255, 0, 16'h00E0, 16'h00D0, 4'b0010, 4'h1);
    repeat (3) @(negedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_s_valid", 32'(s_valid_a), 0);
    chk("mid_rst_s_wr", 32'(s_wr_a), 0);
    chk("mid_rst_s_addr", 32'(s_addr_a), 0);
    chk("mid_rst_s_wdata", 32'(s_wdata_a), 0);
    chk("mid_rst_m_rdata", 32'(m_rdata_a), 0);
    chk("mid_rst_grant_id", 32'(grant_id_a), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    qa.delete();
    last_a = 3;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      chk("mid_rst_m_ready", 32'(m_ready_a), 0);
    end
    reset = 1'b0;
    issue_a(4'b0101, 0, 0, 16'h0F0C, 16'h0102, 4'b0000, 4'h9);
    wait_idle_a();

    // Instance B: back-to-back, full-width data
    m_addr_b = 16'($urandom); m_wdata_b = $urandom; m_wr_b = 2'($urandom);
    for (int k = 0; k < 6; k++) begin
      last_b = next_owner(32'h3, 2, last_b);
      e.master = last_b; e.wr = m_wr_b[last_b];
      e.addr = 32'(m_addr_b[last_b*8 +: 8]); e.wdata = 32'(m_wdata_b[last_b*16 +: 16]);
      e.err = 1'b0; e.rdata = 32'({m_addr_b[last_b*8 +: 8], ~m_addr_b[last_b*8 +: 8]});
      e.issue_cyc = 1;
      qb.push_back(e);
    end
    m_valid_b = 2'b11;
    seen = 0;
    for (int n = 0; n < 100 && seen < 6; n++) begin
      @(negedge clock);
      if (m_ready_b != '0) seen++;
    end
    m_valid_b = '0;
    repeat (4) @(negedge clock);
    if (seen < 6 || qb.size() != 0) flag("b_backtoback_incomplete");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
